sprite_rom_arbiter: RTL and testbench

Shares one single-port sprite ROM (synchronous read, fixed latency) among the pixel-generation requesters: four player sprite fetchers and the grid tile fetcher. It arbitrates every cycle and drives the ROM address port. It returns read data to the winning requester, tagged one-hot. It sits between the graphics pipeline and the sprite BRAM, so that images are stored once instead of once per blob.

---
 rtl/sprite_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port sprite ROM among the player sprite fetchers and the
// grid tile fetcher, returning one-hot tagged pixels in grant order.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 5,
    parameter int PRIO_REQ    = 4,
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 12,
    parameter int ROM_LATENCY = 2,
    parameter int MAX_WAIT    = 7
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] MAX_W3 = 3'(MAX_WAIT);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      cand;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_nxt;
    logic               found;
    int                 nxt;
    logic [2:0]         wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] tag      [ROM_LATENCY];

    // Overdue requester first, then the tile fetcher, then round-robin.
    always_comb begin
        elig    = req & ~gnt;
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && i != PRIO_REQ && elig[i]
                && wait_cnt[i] >= MAX_W3) begin
                found   = 1'b1;
                win_idx = PW'(i);
            end
        end
        if (!found && elig[PRIO_REQ]) begin
            found   = 1'b1;
            win_idx = PW'(PRIO_REQ);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && int'(cand) != PRIO_REQ && elig[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        gnt_nxt = found ? (NUM_REQ'(1) << win_idx) : '0;
        nxt = (int'(win_idx) + 1) % NUM_REQ;
        if (nxt == PRIO_REQ) begin
            nxt = (nxt + 1) % NUM_REQ;
        end
        rr_nxt = PW'(nxt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            rr_ptr   <= '0;
        end else begin
            gnt    <= gnt_nxt;
            rom_en <= found;
            if (found) begin
                rom_addr <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            end
            if (frame_start) begin
                rr_ptr <= '0;
            end else if (found && int'(win_idx) != PRIO_REQ) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i != PRIO_REQ) begin
                    if (!req[i] || gnt_nxt[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (elig[i] && wait_cnt[i] != 3'd7) begin
                        wait_cnt[i] <= wait_cnt[i] + 3'd1;
                    end
                end
            end
        end
    end

    // The tag enters one cycle after the grant so it leaves exactly as
    // rom_data becomes valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                tag[i] <= '0;
            end
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tag[0] <= gnt;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                tag[i] <= tag[i-1];
            end
            rsp_valid <= tag[ROM_LATENCY-1];
            if (|tag[ROM_LATENCY-1]) begin
                rsp_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: reference arbitration model plus a response
// scoreboard checked by an independent monitor.
module tb_sprite_rom_arbiter;

    localparam int NR = 5;
    localparam int PR = 4;
    localparam int AW = 14;
    localparam int DW = 12;
    localparam int L  = 2;
    localparam int MW = 7;

    logic             clock;
    logic             reset_n;
    logic             frame_start;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt;
    logic             rom_en;
    logic [AW-1:0]    rom_addr;
    logic [DW-1:0]    rom_data;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;

    sprite_rom_arbiter #(
        .NUM_REQ(NR), .PRIO_REQ(PR), .ADDR_W(AW),
        .DATA_W(DW), .ROM_LATENCY(L), .MAX_WAIT(MW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [31:0] t;
        t = (a * 29) ^ (a >> 3) ^ 32'h3c5;
        return t[DW-1:0];
    endfunction

    // Behavioural ROM: data appears L cycles after the enabled address.
    logic [DW-1:0] rp [L];
    always @(posedge clock) begin
        rp[0] <= rom_en ? rom_fn(rom_addr) : 12'hbad;
        for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end
    assign rom_data = rp[L-1];

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [NR-1:0] tag;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    int            m_wait [NR];
    int            m_rr;
    logic [NR-1:0] m_gnt;
    logic          m_en;
    logic [AW-1:0] m_addr;

    function automatic int m_winner();
        logic [NR-1:0] el;
        el = req & ~m_gnt;
        for (int i = 0; i < NR; i++)
            if (i != PR && el[i] && m_wait[i] >= MW) return i;
        if (el[PR]) return PR;
        for (int k = 0; k < NR; k++) begin
            int x;
            x = (m_rr + k) % NR;
            if (x != PR && el[x]) return x;
        end
        return -1;
    endfunction

    // Predicts the registered outputs for the next cycle from the inputs now.
    function automatic void predict();
        int w;
        logic [NR-1:0] el;
        exp_t e;
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_wait[i] = 0;
            m_rr = 0; m_gnt = '0; m_en = 1'b0; m_addr = '0;
            return;
        end
        w  = m_winner();
        el = req & ~m_gnt;
        for (int i = 0; i < NR; i++) begin
            if (i == PR) continue;
            if (i == w || !req[i]) m_wait[i] = 0;
            else if (el[i] && m_wait[i] < 7) m_wait[i]++;
        end
        if (frame_start) m_rr = 0;
        else if (w >= 0 && w != PR) begin
            m_rr = (w + 1) % NR;
            if (m_rr == PR) m_rr = (m_rr + 1) % NR;
        end
        if (w >= 0) begin
            m_gnt  = NR'(1) << w;
            m_en   = 1'b1;
            m_addr = req_addr[w*AW +: AW];
            e.tag = m_gnt; e.data = rom_fn(m_addr); e.due = cyc + L + 2;
            q.push_back(e);
        end else begin
            m_gnt = '0;
            m_en  = 1'b0;
        end
    endfunction

    bit starve_on = 0;
    int wc = 0;
    int fs_st = 0;

    task automatic sample();
        @(negedge clock);
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rom_en", 32'(rom_en), 32'(m_en));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
        if (starve_on) begin
            if (gnt[0]) begin
                chk("starve0", 32'(wc <= 8), 32'd1);
                wc = 0;
            end else if (req[0]) wc++;
        end
        if (fs_st != 0 && gnt != 0) begin
            if (fs_st == 1) begin
                chk("fs_grant", 32'(gnt), 32'h4);
                fs_st = 2;
            end else begin
                chk("fs_next", 32'(gnt), 32'h1);
                fs_st = 0;
            end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) q.delete();
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("rsp_onehot", 32'($onehot0(rsp_valid)), 32'd1);
            while (q.size() > 0 && q[0].due < cyc) begin
                total++; bad++;
                $display("FAIL rsp_missing cyc=%0d got=none want_tag=%h",
                         cyc, q[0].tag);
                void'(q.pop_front());
            end
            if (rsp_valid != 0) begin
                if (q.size() == 0) chk("rsp_extra", 32'(rsp_valid), 32'd0);
                else begin
                    e = q.pop_front();
                    chk("rsp_tag", 32'(rsp_valid), 32'(e.tag));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin : driver
        logic [NR-1:0] prev_g;
        bit rst_done;
        int dens;
        reset_n = 1'b0; frame_start = 1'b0; req = '0; req_addr = '0;
        prev_g = '0; rst_done = 0; dens = 50;
        predict();
        repeat (3) begin sample(); predict(); end
        sample();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        reset_n = 1'b1;
        predict();

        // Single requester.
        sample();
        req_addr[0 +: AW] = 14'h0123; req[0] = 1'b1;
        predict();
        repeat (20) begin sample(); predict(); end

        // Round-robin with a frame_start collision on a grant to 2.
        sample();
        req_addr[1*AW +: AW] = 14'h0456;
        req_addr[2*AW +: AW] = 14'h1789;
        req_addr[3*AW +: AW] = 14'h2abc;
        req[3:0] = 4'b1111;
        predict();
        for (int j = 0; j < 24; j++) begin
            sample();
            frame_start = 1'b0;
            if (j >= 8 && fs_st == 0 && j < 12 && m_winner() == 2) begin
                frame_start = 1'b1;
                fs_st = 1;
            end
            predict();
        end
        sample(); frame_start = 1'b0; predict();

        // Tile fetcher plus player 0.
        sample();
        req_addr[4*AW +: AW] = 14'h3def;
        req = 5'b10001;
        predict();
        repeat (16) begin sample(); predict(); end

        // Everyone competing: player 0 must not starve.
        sample();
        req = 5'b11111; starve_on = 1; wc = 0;
        predict();
        repeat (48) begin sample(); predict(); end
        sample(); starve_on = 0; predict();

        // Randomized stress with a reset while reads are in flight.
        for (int j = 0; j < 10000; j++) begin
            sample();
            frame_start = ($urandom_range(0, 49) == 0);
            if (j % 500 == 0) dens = $urandom_range(10, 90);
            for (int i = 0; i < NR; i++) begin
                if (req[i] && gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else req_addr[i*AW +: AW] = AW'($urandom);
                end else if (!req[i] && $urandom_range(0, 99) < dens) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (j >= 5000 && !rst_done && m_gnt != 0 && prev_g != 0) begin
                rst_done = 1;
                reset_n = 1'b0; req = '0; frame_start = 1'b0;
                predict();
                repeat (3) begin sample(); predict(); end
                sample();
                reset_n = 1'b1;
                predict();
                sample();
                chk("rel_gnt", 32'({gnt, rom_en}), 32'd0);
                chk("rel_addr", 32'(rom_addr), 32'd0);
                chk("rel_rsp", 32'(rsp_valid), 32'd0);
                chk("rel_data", 32'(rsp_data), 32'd0);
            end
            prev_g = m_gnt;
            predict();
        end

        sample();
        req = '0; frame_start = 1'b0;
        predict();
        repeat (12) begin sample(); predict(); end
        chk("drain", 32'(q.size()), 32'd0);
        chk("reset_seen", 32'(rst_done), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
